// File: rtl/apb_timer_slave.sv
// APB slave wrapping one 32-bit down-counting timer with prescaler, auto-reload and level interrupt.
// Optional macro APB_TIMER_PSLVERR_EN enables slave-error responses for unmapped offsets and COUNT writes.
`ifndef APB_AW
`define APB_AW 32
`endif
`ifndef APB_DW
`define APB_DW 32
`endif

module apb_timer_slave #(
  parameter int APB_AW      = `APB_AW,
  parameter int APB_DW      = `APB_DW,
  parameter int WAIT_STATES = 1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [APB_AW-1:0]   s_apb_paddr_i,
  input  logic                s_apb_pwrite_i,
  input  logic                s_apb_psel_i,
  input  logic                s_apb_penable_i,
  output logic                s_apb_pready_o,
  input  logic [APB_DW-1:0]   s_apb_pwdata_i,
  input  logic [APB_DW/8-1:0] s_apb_pstrb_i,
  output logic [APB_DW-1:0]   s_apb_rdata_o,
  output logic                s_apb_pslverr_o,
  output logic                irq_o
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  wait_reg, wait_next;
  logic [2:0]  reg_sel;
  logic        pready, err, wr_en;
  logic        wr_ctrl, wr_load, wr_status, wr_prescale;

  logic [2:0]  ctrl_reg, ctrl_next;
  logic [31:0] load_reg, load_next, load_merged;
  logic [31:0] count_reg, count_next;
  logic [15:0] prescale_reg, prescale_next, prescale_merged;
  logic [15:0] pcnt_reg, pcnt_next;
  logic        status_reg, status_next;
  logic [31:0] rdata_reg, rdata_next;
  logic        tick, expire;
  logic        unused_paddr;

  assign reg_sel      = s_apb_paddr_i[4:2];
  assign unused_paddr = ^{s_apb_paddr_i[APB_AW-1:5], s_apb_paddr_i[1:0]};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg <= IDLE;
      wait_reg  <= 3'd0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
    end
  end

  // SETUP/ACCESS share handling: a fresh setup phase reloads the wait counter
  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    case (state_reg)
      IDLE: begin
        if (s_apb_psel_i && !s_apb_penable_i) begin
          state_next = SETUP;
          wait_next  = 3'(WAIT_STATES);
        end
      end
      SETUP, ACCESS: begin
        if (!s_apb_psel_i) begin
          state_next = IDLE;
        end else if (!s_apb_penable_i) begin
          state_next = SETUP;
          wait_next  = 3'(WAIT_STATES);
        end else if (wait_reg != 3'd0) begin
          state_next = ACCESS;
          wait_next  = wait_reg - 3'd1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign pready = s_apb_psel_i && s_apb_penable_i && (wait_reg == 3'd0)
                  && (state_reg == SETUP || state_reg == ACCESS);

`ifdef APB_TIMER_PSLVERR_EN
  assign err = (reg_sel > 3'd4) || (s_apb_pwrite_i && reg_sel == 3'd2);
`else
  assign err = 1'b0;
`endif

  assign wr_en       = pready && s_apb_pwrite_i && !err;
  assign wr_ctrl     = wr_en && reg_sel == 3'd0;
  assign wr_load     = wr_en && reg_sel == 3'd1;
  assign wr_status   = wr_en && reg_sel == 3'd3;
  assign wr_prescale = wr_en && reg_sel == 3'd4;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_load_lane
      assign load_merged[gi*8 +: 8] = s_apb_pstrb_i[gi] ? s_apb_pwdata_i[gi*8 +: 8]
                                                        : load_reg[gi*8 +: 8];
    end
    for (gi = 0; gi < 2; gi++) begin : g_pre_lane
      assign prescale_merged[gi*8 +: 8] = s_apb_pstrb_i[gi] ? s_apb_pwdata_i[gi*8 +: 8]
                                                            : prescale_reg[gi*8 +: 8];
    end
  endgenerate

  assign tick   = ctrl_reg[0] && (pcnt_reg == prescale_reg);
  assign expire = tick && (count_reg == 32'd0);

  // bus writes are applied after the tick so they take priority
  always_comb begin
    ctrl_next     = ctrl_reg;
    load_next     = load_reg;
    count_next    = count_reg;
    prescale_next = prescale_reg;
    pcnt_next     = pcnt_reg;
    status_next   = status_reg;

    if (ctrl_reg[0])
      pcnt_next = tick ? 16'd0 : pcnt_reg + 16'd1;
    if (tick) begin
      if (!expire)
        count_next = count_reg - 32'd1;
      else if (ctrl_reg[1])
        count_next = load_reg;
      else
        ctrl_next[0] = 1'b0;
    end

    if (wr_ctrl && s_apb_pstrb_i[0])
      ctrl_next = s_apb_pwdata_i[2:0];
    if (wr_load) begin
      load_next  = load_merged;
      count_next = load_merged;
      pcnt_next  = 16'd0;
    end
    if (wr_prescale)
      prescale_next = prescale_merged;

    if (expire)
      status_next = 1'b1;
    else if (wr_status && s_apb_pstrb_i[0] && s_apb_pwdata_i[0])
      status_next = 1'b0;
  end

  always_comb begin
    rdata_next = 32'd0;
    case (reg_sel)
      3'd0: rdata_next = {29'd0, ctrl_reg};
      3'd1: rdata_next = load_reg;
      3'd2: rdata_next = count_reg;
      3'd3: rdata_next = {31'd0, status_reg};
      3'd4: rdata_next = {16'd0, prescale_reg};
      default: rdata_next = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ctrl_reg     <= 3'd0;
      load_reg     <= 32'd0;
      count_reg    <= 32'd0;
      prescale_reg <= 16'd0;
      pcnt_reg     <= 16'd0;
      status_reg   <= 1'b0;
      rdata_reg    <= 32'd0;
    end else begin
      ctrl_reg     <= ctrl_next;
      load_reg     <= load_next;
      count_reg    <= count_next;
      prescale_reg <= prescale_next;
      pcnt_reg     <= pcnt_next;
      status_reg   <= status_next;
      rdata_reg    <= rdata_next;
    end
  end

  assign s_apb_pready_o  = pready;
  assign s_apb_rdata_o   = (pready && !s_apb_pwrite_i) ? rdata_reg : '0;
  assign s_apb_pslverr_o = pready && err;
  assign irq_o           = status_reg && ctrl_reg[2];

endmodule

// File: tb/tb_apb_timer_slave.sv
// Self-checking bench for apb_timer_slave: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the timer.
module tb_apb_timer_slave;

  localparam int W = 1;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [31:0] paddr = 32'h0;
  logic        pwrite = 1'b0, psel = 1'b0, penable = 1'b0;
  logic [31:0] pwdata = 32'h0;
  logic [3:0]  pstrb = 4'h0;
  logic        pready, pslverr, irq;
  logic [31:0] rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  apb_timer_slave #(.APB_AW(32), .APB_DW(32), .WAIT_STATES(W)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .s_apb_paddr_i(paddr), .s_apb_pwrite_i(pwrite),
    .s_apb_psel_i(psel), .s_apb_penable_i(penable),
    .s_apb_pready_o(pready), .s_apb_pwdata_i(pwdata),
    .s_apb_pstrb_i(pstrb), .s_apb_rdata_o(rdata),
    .s_apb_pslverr_o(pslverr), .irq_o(irq)
  );

  // ---------------- behavioural timer model ----------------
  typedef struct packed {
    logic [2:0]  ctrl;
    logic [31:0] load;
    logic [31:0] count;
    logic [15:0] pre;
    logic [15:0] pcnt;
    logic        exp;
  } tm_t;

  tm_t  m, m_last;
  logic m_commit = 1'b0;

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] st);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic tm_t step(tm_t s, logic wr, logic [2:0] sel, logic [31:0] d, logic [3:0] st);
    tm_t n = s;
    logic [31:0] tmp;
    bit ticking = (s.ctrl[0] == 1'b1) && (s.pcnt == s.pre);
    bit expiring = ticking && (s.count == 0);
    if (s.ctrl[0]) n.pcnt = ticking ? 16'd0 : s.pcnt + 16'd1;
    if (ticking) begin
      if (!expiring) n.count = s.count - 1;
      else begin
        n.exp = 1'b1;
        if (s.ctrl[1]) n.count = s.load; else n.ctrl[0] = 1'b0;
      end
    end
    if (wr) begin
      case (sel)
        3'd0: if (st[0]) n.ctrl = d[2:0];
        3'd1: begin n.load = merge(s.load, d, st); n.count = n.load; n.pcnt = 16'd0; end
        3'd3: if (st[0] && d[0] && !expiring) n.exp = 1'b0;
        3'd4: begin tmp = merge({16'h0, s.pre}, d, st); n.pre = tmp[15:0]; end
        default: ;
      endcase
    end
    return n;
  endfunction

  function automatic logic [31:0] rd_of(tm_t s, logic [2:0] sel);
    case (sel)
      3'd0: return {29'd0, s.ctrl};
      3'd1: return s.load;
      3'd2: return s.count;
      3'd3: return {31'd0, s.exp};
      3'd4: return {16'd0, s.pre};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      m      <= '0;
      m_last <= '0;
    end else begin
      m_last <= m;
      m      <= step(m, m_commit & pwrite, paddr[4:2], pwdata, pstrb);
    end
  end

  // ---------------- transaction tasks (called at posedge+1) ----------------
  task automatic xfer(input bit wr, input logic [4:0] off, input logic [31:0] d,
                      input logic [3:0] st, output logic [31:0] rd);
    logic [31:0] exp_rd;
    bit exp_err, last;
`ifdef APB_TIMER_PSLVERR_EN
    exp_err = (off[4:2] > 3'd4) || (wr && off[4:2] == 3'd2);
`else
    exp_err = 1'b0;
`endif
    rd = 32'h0;
    paddr = {27'h0, off[4:2], 2'($urandom_range(0, 3))};
    pwrite = wr; pwdata = d; pstrb = wr ? st : 4'h0; psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({pready, pslverr, rdata} !== 34'h0)
      begin n_bad++; $display("FAIL setup off=%h: got pready=%b err=%b rdata=%h want 0", off, pready, pslverr, rdata); end
    n_cmp++;
    if (irq !== (m.exp & m.ctrl[2]))
      begin n_bad++; $display("FAIL irq_setup: got %b want %b", irq, m.exp & m.ctrl[2]); end
    for (int i = 0; i <= W; i++) begin
      @(posedge clk); #1;
      penable = 1'b1;
      last = (i == W);
      m_commit = last;
      @(negedge clk);
      exp_rd = (last && !wr) ? rd_of(m_last, off[4:2]) : 32'h0;
      n_cmp++;
      if ({pready, pslverr, rdata} !== {last, last && exp_err, exp_rd})
        begin n_bad++; $display("FAIL access%0d %s off=%h: got pready=%b err=%b rdata=%h want pready=%b err=%b rdata=%h",
                                i, wr ? "wr" : "rd", off, pready, pslverr, rdata, last, last && exp_err, exp_rd); end
      n_cmp++;
      if (irq !== (m.exp & m.ctrl[2]))
        begin n_bad++; $display("FAIL irq_access: got %b want %b", irq, m.exp & m.ctrl[2]); end
      if (last) rd = rdata;
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; m_commit = 1'b0;
    $display("xfer %s off=%h wdata=%h strb=%b rdata=%h", wr ? "WR" : "RD", off, d, st, rd);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      n_cmp++;
      if ({pready, irq} !== {1'b0, m.exp & m.ctrl[2]})
        begin n_bad++; $display("FAIL idle: got pready=%b irq=%b want 0/%b", pready, irq, m.exp & m.ctrl[2]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic wr32(input logic [4:0] off, input logic [31:0] d, input logic [3:0] st);
    logic [31:0] dummy;
    xfer(1'b1, off, d, st, dummy);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] rd;
    reset_i = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
    repeat (2) @(posedge clk);
    penable = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({pready, pslverr, irq, rdata} !== 35'h0)
      begin n_bad++; $display("FAIL reset_outputs: got pready=%b err=%b irq=%b rdata=%h want 0", pready, pslverr, irq, rdata); end
    @(posedge clk); #1;
    reset_i = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    for (int s = 0; s < 5; s++) begin
      xfer(1'b0, 5'(s * 4), 32'h0, 4'h0, rd);
      n_cmp++;
      if (rd !== 32'h0) begin n_bad++; $display("FAIL reset_reg%0d: got %h want 0", s, rd); end
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd;
    wr32(5'h04, 32'h0000_0005, 4'hF);
    xfer(1'b0, 5'h08, 32'h0, 4'h0, rd);
    n_cmp++;
    if (rd !== 32'h5) begin n_bad++; $display("FAIL count_after_load: got %h want 5", rd); end
  endtask

  task automatic test_autoreload();
    logic [31:0] rd;
    wr32(5'h10, 32'h0, 4'hF);
    wr32(5'h04, 32'h3, 4'hF);
    wr32(5'h00, 32'h7, 4'hF);
    for (int k = 0; k < 4; k++) xfer(1'b0, 5'h08, 32'h0, 4'h0, rd);
    idle(3);
    n_cmp++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL autoreload_irq: got %b want 1", irq); end
    xfer(1'b0, 5'h0C, 32'h0, 4'h0, rd);
    n_cmp++;
    if (rd !== 32'h1) begin n_bad++; $display("FAIL autoreload_status: got %h want 1", rd); end
    wr32(5'h00, 32'h6, 4'hF);
    wr32(5'h0C, 32'h1, 4'hF);
    idle(1);
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL w1c_irq: got %b want 0", irq); end
  endtask

  task automatic test_oneshot();
    logic [31:0] rd;
    wr32(5'h10, 32'h1, 4'hF);
    wr32(5'h04, 32'h2, 4'hF);
    wr32(5'h00, 32'h1, 4'hF);
    idle(20);
    xfer(1'b0, 5'h00, 32'h0, 4'h0, rd);
    n_cmp++;
    if (rd !== 32'h0) begin n_bad++; $display("FAIL oneshot_ctrl: got %h want 0", rd); end
    xfer(1'b0, 5'h08, 32'h0, 4'h0, rd);
    n_cmp++;
    if (rd !== 32'h0) begin n_bad++; $display("FAIL oneshot_count: got %h want 0", rd); end
    xfer(1'b0, 5'h0C, 32'h0, 4'h0, rd);
    n_cmp++;
    if (rd !== 32'h1) begin n_bad++; $display("FAIL oneshot_status: got %h want 1", rd); end
    wr32(5'h0C, 32'h1, 4'hF);
  endtask

  task automatic test_strobe();
    logic [31:0] rd;
    wr32(5'h04, 32'h0, 4'hF);
    wr32(5'h04, 32'h1234_5678, 4'b0101);
    xfer(1'b0, 5'h04, 32'h0, 4'h0, rd);
    n_cmp++;
    if (rd !== 32'h0034_0078) begin n_bad++; $display("FAIL strobe_load: got %h want 00340078", rd); end
    xfer(1'b0, 5'h14, 32'h0, 4'h0, rd);
    n_cmp++;
    if (rd !== 32'h0) begin n_bad++; $display("FAIL unmapped_read: got %h want 0", rd); end
  endtask

  task automatic test_w1c_race();
    logic [31:0] rd;
    wr32(5'h0C, 32'h1, 4'hF);
    wr32(5'h10, 32'h0, 4'hF);
    wr32(5'h04, 32'(W + 1), 4'hF);
    wr32(5'h00, 32'h5, 4'hF);
    wr32(5'h0C, 32'h1, 4'hF);
    xfer(1'b0, 5'h0C, 32'h0, 4'h0, rd);
    n_cmp++;
    if (rd !== 32'h1) begin n_bad++; $display("FAIL w1c_race_status: got %h want 1", rd); end
    n_cmp++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL w1c_race_irq: got %b want 1", irq); end
    wr32(5'h0C, 32'h1, 4'hF);
  endtask

  task automatic test_psel_drop();
    logic [31:0] rd;
    wr32(5'h04, 32'h11, 4'hF);
    paddr = 32'h4; pwrite = 1'b1; pwdata = 32'hDEAD_BEEF; pstrb = 4'hF; psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (pready !== 1'b0) begin n_bad++; $display("FAIL psel_drop_pready: got %b want 0", pready); end
    @(posedge clk); #1;
    penable = 1'b0; pwrite = 1'b0;
    idle(1);
    xfer(1'b0, 5'h04, 32'h0, 4'h0, rd);
    n_cmp++;
    if (rd !== 32'h11) begin n_bad++; $display("FAIL psel_drop_load: got %h want 11", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic [31:0] v;
    for (int k = 0; k < 4; k++) begin
      v = $urandom();
      wr32(5'h04, v, 4'hF);
      xfer(1'b0, 5'h04, 32'h0, 4'h0, rd);
      n_cmp++;
      if (rd !== v) begin n_bad++; $display("FAIL b2b_load: got %h want %h", rd, v); end
    end
    wr32(5'h10, 32'h0000_ABCD, 4'h3);
    xfer(1'b0, 5'h10, 32'h0, 4'h0, rd);
    n_cmp++;
    if (rd !== 32'h0000_ABCD) begin n_bad++; $display("FAIL b2b_prescale: got %h want 0000abcd", rd); end
    wr32(5'h10, 32'h0, 4'hF);
  endtask

  task automatic test_random();
    logic [31:0] rd, d;
    logic [2:0]  sel;
    bit          wr;
    for (int k = 0; k < 60; k++) begin
      sel = 3'($urandom_range(0, 7));
      wr  = 1'($urandom_range(0, 1));
      case (sel)
        3'd1:    d = 32'($urandom_range(0, 12));
        3'd4:    d = 32'($urandom_range(0, 3));
        3'd0, 3'd3: d = 32'($urandom_range(0, 7));
        default: d = $urandom();
      endcase
      xfer(wr, {sel, 2'b00}, d, 4'($urandom_range(0, 15)), rd);
      idle($urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_wait_states();
    test_autoreload();
    test_oneshot();
    test_strobe();
    test_w1c_race();
    test_psel_drop();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
